ct_split_reg: RTL and testbench

//  One-to-many split node: the dual of the merge node. Takes one packet stream and

---
 rtl/ct_split_reg.sv | 115 +++++++++++
 tb/tb_ct_split_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_split_reg.sv
// ct_split_reg: one-to-many split node with a single registered output stage.
// Each accepted beat is held once and offered to every output selected by the
// packet's destination mask. Outputs acknowledge independently, and the beat
// retires once every selected output has taken it.
//
// Handshake: a beat moves across an interface on a cycle where its valid and
// ready are both high. Input side: i_valid/o_ready. Output side k:
// o_valid[k]/i_ready[k]. Valid never waits on ready. o_ready is combinational
// from i_ready so that a retiring beat can be replaced on the same edge.
module ct_split_reg #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_eop,
  input  logic [NO-1:0]    i_mask,
  output logic [WIDTH-1:0] o_data,
  output logic [NO-1:0]    o_valid,
  input  logic [NO-1:0]    i_ready,
  output logic             o_eop
);

  // EMPTY: nothing owed to any output. HOLD: at least one output still owed.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Debug view of the holding state, derived from the pending bits.
  state_e state_dbg;

  logic [WIDTH-1:0] data_q, data_d;
  logic             eop_q, eop_d;
  logic [NO-1:0]    pending_q, pending_d;
  logic [NO-1:0]    lmask_q, lmask_d;
  logic             sop_q, sop_d;

  logic             done;
  logic             accept;
  logic [NO-1:0]    sel_mask;

  // Classify the held beat for debug and for the input-ready decision.
  always_comb begin
    state_dbg = (pending_q == '0) ? ST_EMPTY : ST_HOLD;
  end

  // Input handshake: free when empty or when every owed output takes it now.
  always_comb begin
    done     = ((pending_q & ~i_ready) == '0);
    o_ready  = reset & ((state_dbg == ST_EMPTY) | done);
    accept   = i_valid & o_ready;
    // Only the first beat of a packet chooses destinations; the rest follow it.
    sel_mask = sop_q ? i_mask : lmask_q;
  end

  // Next-state: clear bits of outputs that transferred, then load a new beat.
  always_comb begin
    data_d    = data_q;
    eop_d     = eop_q;
    lmask_d   = lmask_q;
    sop_d     = sop_q;
    pending_d = pending_q & ~i_ready;
    if (accept) begin
      if (sop_q) begin
        lmask_d = i_mask;
      end
      data_d    = i_data;
      eop_d     = i_eop;
      // A zero mask leaves pending clear, so the beat is silently dropped.
      pending_d = sel_mask;
      sop_d     = i_eop;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q    <= '0;
      eop_q     <= 1'b0;
      pending_q <= '0;
      lmask_q   <= '0;
      sop_q     <= 1'b1;
    end else begin
      data_q    <= data_d;
      eop_q     <= eop_d;
      pending_q <= pending_d;
      lmask_q   <= lmask_d;
      sop_q     <= sop_d;
    end
  end

  // Outputs: valid is gated by reset so nothing is offered while held in reset.
  always_comb begin
    o_valid = pending_q & {NO{reset}};
    o_data  = data_q;
    o_eop   = eop_q;
  end

  // Held beat must not change while it is still owed and nothing new is taken.
  a_hold_stable: assert property (
    @(posedge clk) disable iff (!reset)
    ((pending_q != '0) && !accept) |=> ($stable(data_q) && $stable(eop_q))
  );

  // A beat is only ever owed to outputs in the packet's locked mask.
  a_within_mask: assert property (
    @(posedge clk) disable iff (!reset)
    ((pending_q & ~lmask_q) == '0)
  );

endmodule

// File: tb/tb_ct_split_reg.sv
// Bench for ct_split_reg: directed scenarios with literal expectations, a
// per-cycle compare against a packet-level model, and per-output queues of
// beats each output is owed.
module tb_ct_split_reg;
  localparam int NO    = 2;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_eop;
  logic [NO-1:0]    i_mask;
  logic [WIDTH-1:0] o_data;
  logic [NO-1:0]    o_valid;
  logic [NO-1:0]    i_ready;
  logic             o_eop;

  int n_cmp = 0;
  int n_err = 0;

  ct_split_reg #(.NO(NO), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_eop(i_eop), .i_mask(i_mask), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_eop(o_eop)
  );

  // Clock and reset initial values
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_eop   = 1'b0;
    i_mask  = '0;
    i_ready = '0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: the beat on display, which outputs still owe it,
  // the destinations chosen by the current packet, and whether the next
  // accepted beat starts a packet.
  logic [WIDTH-1:0] m_data     = '0;
  logic             m_eop      = 1'b0;
  logic [NO-1:0]    m_owed     = '0;
  logic [NO-1:0]    m_pkt_mask = '0;
  logic             m_sop      = 1'b1;
  logic             m_acc;
  logic [WIDTH:0]   exp_q[NO][$];

  // The source may hand over a beat when no owed output is left waiting.
  function automatic logic model_ready();
    logic r;
    r = reset;
    for (int k = 0; k < NO; k++)
      if (m_owed[k] && !i_ready[k]) r = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_owed     = '0;
      m_pkt_mask = '0;
      m_sop      = 1'b1;
      m_data     = '0;
      m_eop      = 1'b0;
      for (int k = 0; k < NO; k++) exp_q[k].delete();
    end else begin
      m_acc = i_valid && model_ready();
      for (int k = 0; k < NO; k++)
        if (m_owed[k] && i_ready[k]) m_owed[k] = 1'b0;
      if (m_acc) begin
        if (m_sop) m_pkt_mask = i_mask;
        m_data = i_data;
        m_eop  = i_eop;
        m_owed = m_pkt_mask;
        m_sop  = i_eop;
        for (int k = 0; k < NO; k++)
          if (m_pkt_mask[k]) exp_q[k].push_back({i_eop, i_data});
      end
    end
  end

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    logic [NO-1:0]  exp_v;
    logic [WIDTH:0] exp_beat;
    exp_v = reset ? m_owed : '0;
    check("m_o_valid", 32'(o_valid), 32'(exp_v));
    check("m_o_ready", 32'(o_ready), 32'(model_ready()));
    if (exp_v != '0) begin
      check("m_o_data", 32'(o_data), 32'(m_data));
      check("m_o_eop", 32'(o_eop), 32'(m_eop));
    end
    for (int k = 0; k < NO; k++) begin
      if (reset && o_valid[k] && i_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          check("sb_unexpected_beat", 32'(k), 32'hFFFF);
        end else begin
          exp_beat = exp_q[k].pop_front();
          check("sb_beat", 32'({o_eop, o_data}), 32'(exp_beat));
        end
      end
    end
  end

  // Driver: apply one cycle of inputs just after the edge, return mid-cycle.
  task automatic cyc(input logic rst, input logic v, input logic [7:0] d,
                     input logic e, input logic [1:0] m, input logic [1:0] r);
    @(posedge clk);
    #1;
    reset   = rst;
    i_valid = v;
    i_data  = d;
    i_eop   = e;
    i_mask  = m;
    i_ready = r;
    @(negedge clk);
  endtask

  initial begin
    // T1: reset held with i_valid high
    cyc(0, 1, 8'h5a, 1, 2'b11, 2'b11);
    check("t1_ready0", 32'(o_ready), 0);
    check("t1_valid0", 32'(o_valid), 0);
    check("t1_data0", 32'(o_data), 0);
    check("t1_eop0", 32'(o_eop), 0);
    cyc(0, 1, 8'h5a, 1, 2'b11, 2'b11);
    check("t1_ready1", 32'(o_ready), 0);
    check("t1_valid1", 32'(o_valid), 0);
    cyc(0, 1, 8'h5a, 1, 2'b11, 2'b11);
    check("t1_ready2", 32'(o_ready), 0);
    check("t1_valid2", 32'(o_valid), 0);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t1_ready_release", 32'(o_ready), 1);

    // T2: unicast 4-beat packet to output 1
    cyc(1, 1, 8'hA0, 0, 2'b10, 2'b11);
    check("t2_ready", 32'(o_ready), 1);
    check("t2_valid_b0", 32'(o_valid), 0);
    cyc(1, 1, 8'hA1, 0, 2'b10, 2'b11);
    check("t2_valid_b1", 32'(o_valid), 2'b10);
    check("t2_data_b1", 32'(o_data), 8'hA0);
    check("t2_eop_b1", 32'(o_eop), 0);
    cyc(1, 1, 8'hA2, 0, 2'b10, 2'b11);
    check("t2_data_b2", 32'(o_data), 8'hA1);
    cyc(1, 1, 8'hA3, 1, 2'b10, 2'b11);
    check("t2_data_b3", 32'(o_data), 8'hA2);
    check("t2_eop_b3", 32'(o_eop), 0);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t2_valid_b4", 32'(o_valid), 2'b10);
    check("t2_data_b4", 32'(o_data), 8'hA3);
    check("t2_eop_b4", 32'(o_eop), 1);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t2_idle", 32'(o_valid), 0);

    // T3: multicast with output 1 slow for three cycles
    cyc(1, 1, 8'hB0, 1, 2'b11, 2'b11);
    cyc(1, 1, 8'hC0, 1, 2'b11, 2'b01);
    check("t3_valid_c1", 32'(o_valid), 2'b11);
    check("t3_ready_c1", 32'(o_ready), 0);
    check("t3_data_c1", 32'(o_data), 8'hB0);
    cyc(1, 1, 8'hC0, 1, 2'b11, 2'b01);
    check("t3_valid_c2", 32'(o_valid), 2'b10);
    check("t3_ready_c2", 32'(o_ready), 0);
    cyc(1, 1, 8'hC0, 1, 2'b11, 2'b01);
    check("t3_valid_c3", 32'(o_valid), 2'b10);
    check("t3_ready_c3", 32'(o_ready), 0);
    cyc(1, 1, 8'hC0, 1, 2'b11, 2'b11);
    check("t3_valid_c4", 32'(o_valid), 2'b10);
    check("t3_ready_c4", 32'(o_ready), 1);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t3_valid_next", 32'(o_valid), 2'b11);
    check("t3_data_next", 32'(o_data), 8'hC0);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t3_idle", 32'(o_valid), 0);

    // T4: mask locked by the first beat
    cyc(1, 1, 8'hD0, 0, 2'b01, 2'b11);
    cyc(1, 1, 8'hD1, 0, 2'b10, 2'b11);
    check("t4_valid_b0", 32'(o_valid), 2'b01);
    cyc(1, 1, 8'hD2, 1, 2'b10, 2'b11);
    check("t4_valid_b1", 32'(o_valid), 2'b01);
    check("t4_data_b1", 32'(o_data), 8'hD1);
    cyc(1, 1, 8'hE0, 1, 2'b10, 2'b11);
    check("t4_valid_b2", 32'(o_valid), 2'b01);
    check("t4_eop_b2", 32'(o_eop), 1);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t4_valid_next", 32'(o_valid), 2'b10);
    check("t4_data_next", 32'(o_data), 8'hE0);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t4_idle", 32'(o_valid), 0);

    // T5: zero-mask packet dropped, next packet delivered
    cyc(1, 1, 8'hF0, 0, 2'b00, 2'b11);
    check("t5_ready_b0", 32'(o_ready), 1);
    cyc(1, 1, 8'hF1, 1, 2'b11, 2'b11);
    check("t5_ready_b1", 32'(o_ready), 1);
    check("t5_valid_b1", 32'(o_valid), 0);
    cyc(1, 1, 8'h6C, 1, 2'b11, 2'b11);
    check("t5_valid_b2", 32'(o_valid), 0);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t5_valid_next", 32'(o_valid), 2'b11);
    check("t5_data_next", 32'(o_data), 8'h6C);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t5_idle", 32'(o_valid), 0);

    // T6: reset mid-packet with both outputs owed
    cyc(1, 1, 8'h90, 0, 2'b11, 2'b11);
    cyc(1, 1, 8'h91, 0, 2'b11, 2'b11);
    check("t6_data_b0", 32'(o_data), 8'h90);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b00);
    check("t6_valid_b1", 32'(o_valid), 2'b11);
    check("t6_data_b1", 32'(o_data), 8'h91);
    cyc(0, 1, 8'h92, 0, 2'b11, 2'b00);
    check("t6_valid_rst", 32'(o_valid), 0);
    cyc(0, 0, 8'h00, 0, 2'b00, 2'b00);
    check("t6_valid_rst2", 32'(o_valid), 0);
    cyc(1, 1, 8'h93, 1, 2'b01, 2'b11);
    check("t6_ready_rel", 32'(o_ready), 1);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("t6_valid_sop", 32'(o_valid), 2'b01);
    check("t6_data_sop", 32'(o_data), 8'h93);
    check("t6_eop_sop", 32'(o_eop), 1);
    cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);

    // Mixed traffic with random stalls, checked by the model and queues
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 0, 2'b00, 2'b11);
    check("drain_q0", 32'(exp_q[0].size()), 0);
    check("drain_q1", 32'(exp_q[1].size()), 0);
    check("drain_valid", 32'(o_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
